// File: rtl/consmax_bus_collector.sv
// consmax_bus_collector: packs per-head consmax byte lanes into words, buffers them per head
// and drains all heads through one round-robin output port.
module consmax_bus_collector #(
    parameter int ODATA_BIT  = 8,
    parameter int GBUS_WIDTH = 4,
    parameter int GBUS_DATA  = ODATA_BIT * GBUS_WIDTH,
    parameter int NUM_HEAD   = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            rstn,
    input  logic [GBUS_DATA*NUM_HEAD-1:0]   odata,
    input  logic [GBUS_WIDTH*NUM_HEAD-1:0]  odata_valid,
    input  logic                            flush,
    input  logic                            clr_overflow,
    input  logic                            out_ready,
    output logic                            out_valid,
    output logic [GBUS_DATA-1:0]            out_data,
    output logic [$clog2(NUM_HEAD)-1:0]     out_head,
    output logic [2:0]                      out_bytes,
    output logic [NUM_HEAD-1:0]             overflow,
    output logic                            busy
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int TW = $clog2(2 * GBUS_WIDTH);
    localparam int HW = $clog2(NUM_HEAD);

    logic [GBUS_DATA-1:0] head_data [NUM_HEAD];
    logic [2:0]           head_len  [NUM_HEAD];
    logic [NUM_HEAD-1:0]  nz, pop, drop, busy_h;
    logic [HW-1:0]        last, lock_head, sel, rr;
    logic                 lock, found;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return p == PW'(FIFO_DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    for (genvar h = 0; h < NUM_HEAD; h++) begin : g_head
        logic [2*GBUS_DATA-1:0] bytes_q;
        logic [GBUS_DATA-1:0]   acc, rem_data, w0;
        logic [TW-1:0]          fill, total, rem;
        logic [2:0]             l0;
        logic [1:0]             npush;
        logic [CW-1:0]          cnt, space;
        logic [PW-1:0]          wp, rp, wp1;
        logic                   full_w, tail, ok0, ok1;
        logic [GBUS_DATA-1:0]   mem [FIFO_DEPTH];
        logic [2:0]             len [FIFO_DEPTH];
        // Bytes above the current fill are always zero, so the packed buffer needs no masking.
        always_comb begin
            bytes_q = {{GBUS_DATA{1'b0}}, acc};
            total = fill;
            for (int l = 0; l < GBUS_WIDTH; l++) begin
                if (odata_valid[h*GBUS_WIDTH+l]) begin
                    bytes_q[total*ODATA_BIT +: ODATA_BIT] = odata[h*GBUS_DATA+l*ODATA_BIT +: ODATA_BIT];
                    total = total + 1'b1;
                end
            end
            full_w = total >= TW'(GBUS_WIDTH);
            rem = full_w ? total - TW'(GBUS_WIDTH) : total;
            tail = flush && rem != '0;
            rem_data = full_w ? bytes_q[2*GBUS_DATA-1:GBUS_DATA] : bytes_q[GBUS_DATA-1:0];
            w0 = full_w ? bytes_q[GBUS_DATA-1:0] : rem_data;
            l0 = full_w ? 3'(GBUS_WIDTH) : 3'(rem);
            npush = {1'b0, full_w} + {1'b0, tail};
        end
        assign pop[h]    = out_valid && out_ready && sel == HW'(h);
        assign space     = CW'(FIFO_DEPTH) - cnt + CW'(pop[h]);
        assign ok0       = npush != 2'd0 && space != '0;
        assign ok1       = npush == 2'd2 && space > CW'(1);
        assign drop[h]   = CW'(npush) > space;
        assign wp1       = nxt(wp);
        assign nz[h]     = cnt != '0;
        assign busy_h[h] = fill != '0 || cnt != '0;
        assign head_data[h] = mem[rp];
        assign head_len[h]  = len[rp];
        always_ff @(posedge clk) begin
            if (ok0) begin
                mem[wp] <= w0;
                len[wp] <= l0;
            end
            if (ok1) begin
                mem[wp1] <= rem_data;
                len[wp1] <= 3'(rem);
            end
        end
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                acc  <= '0;
                fill <= '0;
                wp   <= '0;
                rp   <= '0;
                cnt  <= '0;
            end else begin
                acc  <= flush ? '0 : rem_data;
                fill <= flush ? '0 : rem;
                wp   <= ok1 ? nxt(wp1) : ok0 ? wp1 : wp;
                rp   <= pop[h] ? nxt(rp) : rp;
                cnt  <= cnt + CW'(ok0) + CW'(ok1) - CW'(pop[h]);
            end
        end
    end

    // Round-robin search begins just after the last granted head; a stalled grant stays locked.
    always_comb begin
        found = 1'b0;
        rr = '0;
        for (int i = 1; i <= NUM_HEAD; i++) begin
            if (!found && nz[(int'(last) + i) % NUM_HEAD]) begin
                rr = HW'((int'(last) + i) % NUM_HEAD);
                found = 1'b1;
            end
        end
        sel = lock ? lock_head : rr;
    end

    assign out_valid = lock || found;
    assign out_data  = out_valid ? head_data[sel] : '0;
    assign out_head  = out_valid ? sel : '0;
    assign out_bytes = out_valid ? head_len[sel] : '0;
    assign busy      = |busy_h;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            last      <= HW'(NUM_HEAD - 1);
            lock      <= 1'b0;
            lock_head <= '0;
            overflow  <= '0;
        end else begin
            last      <= out_valid && out_ready ? sel : last;
            lock      <= out_valid && !out_ready;
            lock_head <= sel;
            overflow  <= (clr_overflow ? '0 : overflow) | drop;
        end
    end
endmodule

// File: tb/tb_consmax_bus_collector.sv
// tb_consmax_bus_collector: directed and random stimulus checked against a byte-queue model.
module tb_consmax_bus_collector;
    localparam int NH = 4;
    localparam int FD = 4;

    logic         clk = 0, rstn = 0;
    logic [127:0] odata = '0;
    logic [15:0]  odata_valid = '0;
    logic         flush = 0, clr_overflow = 0, out_ready = 0;
    logic         out_valid, busy;
    logic [31:0]  out_data;
    logic [1:0]   out_head;
    logic [2:0]   out_bytes;
    logic [3:0]   overflow;

    int checks = 0, failures = 0;
    byte unsigned accq [NH][$];
    logic [34:0]  fq [NH][$];
    int           last = NH - 1, stall = -1;
    logic [3:0]   ov = '0;
    logic [31:0]  w;

    consmax_bus_collector dut (
        .clk(clk), .rstn(rstn), .odata(odata), .odata_valid(odata_valid), .flush(flush),
        .clr_overflow(clr_overflow), .out_ready(out_ready), .out_valid(out_valid),
        .out_data(out_data), .out_head(out_head), .out_bytes(out_bytes),
        .overflow(overflow), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick();
        if (stall >= 0) return stall;
        for (int i = 1; i <= NH; i++)
            if (fq[(last + i) % NH].size() != 0) return (last + i) % NH;
        return -1;
    endfunction

    task automatic model_reset();
        for (int h = 0; h < NH; h++) begin
            accq[h].delete();
            fq[h].delete();
        end
        last = NH - 1;
        stall = -1;
        ov = '0;
    endtask

    task automatic check_outputs();
        int s = pick();
        logic [34:0] e = '0;
        logic eb = 1'b0;
        if (s >= 0) e = fq[s][0];
        for (int h = 0; h < NH; h++) if (accq[h].size() != 0 || fq[h].size() != 0) eb = 1'b1;
        chk("out_valid", 32'(out_valid), 32'(s >= 0));
        chk("out_data", out_data, e[31:0]);
        chk("out_head", 32'(out_head), s >= 0 ? 32'(s) : 32'd0);
        chk("out_bytes", 32'(out_bytes), 32'(e[34:32]));
        chk("overflow", 32'(overflow), 32'(ov));
        chk("busy", 32'(busy), 32'(eb));
    endtask

    function automatic logic [34:0] take(int h, int n);
        logic [31:0] d = '0;
        for (int i = 0; i < n; i++) d[i*8 +: 8] = accq[h].pop_front();
        return {3'(n), d};
    endfunction

    task automatic fpush(int h, logic [34:0] e);
        if (fq[h].size() < FD) fq[h].push_back(e);
        else ov[h] = 1'b1;
    endtask

    task automatic model_edge();
        int s = pick();
        if (!rstn) begin
            model_reset();
            return;
        end
        if (s >= 0 && out_ready) begin
            void'(fq[s].pop_front());
            last = s;
        end
        stall = (s >= 0 && !out_ready) ? s : -1;
        if (clr_overflow) ov = '0;
        for (int h = 0; h < NH; h++) begin
            for (int l = 0; l < 4; l++)
                if (odata_valid[h*4+l]) accq[h].push_back(odata[h*32+l*8 +: 8]);
            if (accq[h].size() >= 4) fpush(h, take(h, 4));
            if (flush && accq[h].size() > 0) fpush(h, take(h, accq[h].size()));
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        check_outputs();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        odata_valid = '0;
        flush = 0;
        clr_overflow = 0;
    endtask

    initial begin
        model_reset();
        repeat (2) cycle();
        rstn = 1;
        // all four heads complete a word together
        out_ready = 1;
        odata = {$urandom, $urandom, $urandom, $urandom};
        odata_valid = '1;
        cycle();
        idle();
        for (int k = 0; k < 4; k++) begin
            chk("r31_head", 32'(out_head), 32'(k));
            cycle();
        end
        // single full word on head 0
        odata[31:0] = 32'h44332211;
        odata_valid = 16'h000F;
        cycle();
        idle();
        chk("r29_data", out_data, 32'h44332211);
        chk("r29_head", 32'(out_head), 32'd0);
        chk("r29_bytes", 32'(out_bytes), 32'd4);
        cycle();
        // sparse lanes on head 1, then flush of the leftover byte
        odata[63:32] = 32'h00BB00AA;
        odata_valid = 16'h0050;
        cycle();
        odata[63:32] = 32'h00C3C2C1;
        odata_valid = 16'h0070;
        cycle();
        idle();
        chk("r30_word", out_data, 32'hC2C1BBAA);
        chk("r30_head", 32'(out_head), 32'd1);
        flush = 1;
        cycle();
        idle();
        chk("r30_tail", out_data, 32'h000000C3);
        chk("r30_bytes", 32'(out_bytes), 32'd1);
        cycle();
        // head 2 overflows while output is stalled
        out_ready = 0;
        odata_valid = 16'h0F00;
        repeat (5) begin
            odata[95:64] = $urandom;
            cycle();
        end
        idle();
        chk("r32_ovf", 32'(overflow), 32'h4);
        chk("r32_busy", 32'(busy), 32'd1);
        clr_overflow = 1;
        cycle();
        idle();
        chk("r32_clr", 32'(overflow), 32'h0);
        out_ready = 1;
        repeat (5) cycle();
        // stalled grant holds while head 0 and head 3 keep filling
        out_ready = 0;
        odata = {$urandom, $urandom, $urandom, $urandom};
        w = odata[31:0];
        odata_valid = 16'h000F;
        cycle();
        odata_valid = 16'hF00F;
        repeat (3) begin
            odata = {$urandom, $urandom, $urandom, $urandom};
            chk("r33_hold", out_data, w);
            chk("r33_head", 32'(out_head), 32'd0);
            cycle();
        end
        idle();
        out_ready = 1;
        repeat (8) cycle();
        // asynchronous reset with partial fill and queued words
        out_ready = 0;
        odata_valid = 16'h000F;
        cycle();
        cycle();
        odata_valid = 16'h0003;
        cycle();
        idle();
        chk("r34_busy_pre", 32'(busy), 32'd1);
        #2 rstn = 0;
        #1;
        chk("r34_valid", 32'(out_valid), 32'd0);
        chk("r34_busy", 32'(busy), 32'd0);
        model_reset();
        check_outputs();
        repeat (2) cycle();
        rstn = 1;
        out_ready = 1;
        repeat (3) cycle();
        // random traffic
        repeat (400) begin
            odata = {$urandom, $urandom, $urandom, $urandom};
            odata_valid = 16'($urandom) & 16'($urandom);
            flush = $urandom_range(0, 7) == 0;
            clr_overflow = $urandom_range(0, 15) == 0;
            out_ready = $urandom_range(0, 3) != 0;
            cycle();
        end
        idle();
        out_ready = 1;
        flush = 1;
        cycle();
        idle();
        repeat (20) cycle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
